servo_move_sequencer: RTL and testbench

// Timed motion-command sequencer that sits directly upstream of the servo controller.

---
 rtl/servo_move_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_servo_move_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_move_sequencer.sv
// servo_move_sequencer
// Plays buffered {direction, duration_ms} commands into the servo controller.
// Each command gets one useServo strobe on entry to RUN and is held for
// duration_ms * TICKS_PER_MS cycles. When the queue drains the sequencer
// returns the robot to stop (000) with a final strobe.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | first cycle after reset release; issues the stop strobe
// IDLE  | queue empty, direction held at stop; pops when a command lands
// LOAD  | popped command latched; zero-length commands skip RUN
// RUN   | holding direction, counting ticks and milliseconds
// DONE  | hold expired, done pulse; chain to next command or stop
module servo_move_sequencer #(
  parameter int TICKS_PER_MS = 50000,
  parameter int FIFO_DEPTH   = 4,
  parameter int DUR_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_dir,
  input  logic [DUR_W-1:0] cmd_ms,
  input  logic             abort,
  output logic [2:0]       direction,
  output logic             useServo,
  output logic             busy,
  output logic             done
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            r_state;
  logic [2:0]        r_direction;
  logic              r_use_servo;
  logic              r_done;
  logic [2:0]        r_cur_dir;
  logic [DUR_W-1:0]  r_ms_left;
  logic [TICK_W-1:0] r_tick;

  logic [2:0]        r_mem_dir [FIFO_DEPTH];
  logic [DUR_W-1:0]  r_mem_ms  [FIFO_DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic [2:0]        w_dir_clean;
  logic [2:0]        w_head_dir;
  logic [DUR_W-1:0]  w_head_ms;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  // Ready ignores a same-cycle pop so it never depends on FSM decisions.
  assign cmd_ready = !w_full && !abort;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_flush   = abort && (r_state != ST_INIT);
  assign w_pop     = !abort && !w_empty &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Unknown direction codes are stored as stop.
  assign w_dir_clean = (cmd_dir > 3'd4) ? 3'd0 : cmd_dir;
  assign w_head_dir  = r_mem_dir[r_rd_ptr[ADDR_W-1:0]];
  assign w_head_ms   = r_mem_ms[r_rd_ptr[ADDR_W-1:0]];

  // INIT is excluded so busy reads 0 straight out of reset.
  assign busy      = ((r_state != ST_IDLE) && (r_state != ST_INIT)) || !w_empty;
  assign direction = r_direction;
  assign useServo  = r_use_servo;
  assign done      = r_done;

  // Command storage; data needs no reset since pointers qualify it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dir[r_wr_ptr[ADDR_W-1:0]] <= w_dir_clean;
      r_mem_ms[r_wr_ptr[ADDR_W-1:0]]  <= cmd_ms;
    end
  end

  // FIFO pointers; a flush snaps the read pointer onto the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Sequencer FSM with registered direction/strobe/done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_direction <= 3'd0;
      r_use_servo <= 1'b0;
      r_done      <= 1'b0;
      r_cur_dir   <= 3'd0;
      r_ms_left   <= '0;
      r_tick      <= '0;
    end else begin
      r_use_servo <= 1'b0;
      r_done      <= 1'b0;
      if (w_flush) begin
        r_state     <= ST_IDLE;
        r_direction <= 3'd0;
        r_use_servo <= 1'b1;
        r_ms_left   <= '0;
        r_tick      <= '0;
      end else begin
        case (r_state)
          ST_INIT: begin
            r_direction <= 3'd0;
            r_use_servo <= 1'b1;
            r_state     <= ST_IDLE;
          end
          ST_IDLE: begin
            r_direction <= 3'd0;
            if (w_pop) begin
              r_cur_dir <= w_head_dir;
              r_ms_left <= w_head_ms;
              r_state   <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            r_tick <= '0;
            if (r_ms_left == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_direction <= r_cur_dir;
              r_use_servo <= 1'b1;
              r_state     <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (r_tick == TICK_LAST) begin
              r_tick    <= '0;
              r_ms_left <= r_ms_left - 1'b1;
              if (r_ms_left == DUR_W'(1)) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          ST_DONE: begin
            if (w_pop) begin
              r_cur_dir <= w_head_dir;
              r_ms_left <= w_head_ms;
              r_state   <= ST_LOAD;
            end else begin
              r_direction <= 3'd0;
              r_use_servo <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Directed bench for servo_move_sequencer at 10 ticks per millisecond.
module tb_servo_move_sequencer;

  localparam int DUR_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_dir;
  logic [DUR_W-1:0] cmd_ms;
  logic             abort;
  logic [2:0]       direction;
  logic             useServo;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  servo_move_sequencer #(
    .TICKS_PER_MS(10),
    .FIFO_DEPTH  (4),
    .DUR_W       (DUR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_ms   (cmd_ms),
    .abort    (abort),
    .direction(direction),
    .useServo (useServo),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] d, input int ms);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_ms    = DUR_W'(ms);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Ticks until useServo is seen; n = -1 if the bound expires.
  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!useServo && n < limit);
    if (!useServo) n = -1;
  endtask

  // Ticks until done is seen; also reports any strobe along the way.
  task automatic wait_done(input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    do begin
      tick();
      n++;
      if (useServo) seen = 1'b1;
    end while (!done && n < limit);
    if (!done) n = -1;
  endtask

  initial begin
    int  n;
    int  k;
    int  dones;
    bit  seen;
    bit  prev_done;
    bit  bad;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 3'd0;
    cmd_ms    = '0;
    abort     = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_use", 32'(useServo), 0);
    chk("rst_dir", 32'(direction), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    tick();
    chk("init_use", 32'(useServo), 1);
    chk("init_dir", 32'(direction), 0);
    tick();
    chk("idle_use", 32'(useServo), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(cmd_ready), 1);

    // Single command {001,3}
    push(3'b001, 3);
    chk("one_busy", 32'(busy), 1);
    wait_strobe(10, n);
    chk("one_strobe_lat", 32'(n), 2);
    chk("one_dir", 32'(direction), 1);
    wait_done(100, n, seen);
    chk("one_run_len", 32'(n), 30);
    chk("one_no_strobe", 32'(seen), 0);
    tick();
    chk("one_stop_use", 32'(useServo), 1);
    chk("one_stop_dir", 32'(direction), 0);
    chk("one_done_1cyc", 32'(done), 0);
    tick();
    chk("one_use_low", 32'(useServo), 0);
    chk("one_idle_busy", 32'(busy), 0);

    // Back-to-back {001,2},{011,1}
    push(3'b001, 2);
    push(3'b011, 1);
    wait_strobe(10, n);
    chk("b2b_s1_lat", 32'(n), 1);
    chk("b2b_s1_dir", 32'(direction), 1);
    wait_done(100, n, seen);
    chk("b2b_d1_len", 32'(n), 20);
    chk("b2b_d1_nostrobe", 32'(seen), 0);
    wait_strobe(10, n);
    chk("b2b_s2_lat", 32'(n), 2);
    chk("b2b_s2_dir", 32'(direction), 3);
    wait_done(100, n, seen);
    chk("b2b_d2_len", 32'(n), 10);
    tick();
    chk("b2b_stop_use", 32'(useServo), 1);
    chk("b2b_stop_dir", 32'(direction), 0);
    tick();

    // Fill while first command runs
    push(3'b001, 2);
    wait_strobe(10, n);
    chk("fill_a_strobe", 32'(n), 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_ready_%0d", i), 32'(cmd_ready), 1);
      push(3'b010, 1);
    end
    chk("fill_full", 32'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_dir   = 3'b100;
    cmd_ms    = DUR_W'(1);
    prev_done = 1'b0;
    k = 0;
    while (!cmd_ready && k < 60) begin
      prev_done = done;
      tick();
      k++;
    end
    chk("fill_held_ready", 32'(cmd_ready), 1);
    chk("fill_release_after_done", 32'(prev_done), 1);
    tick();
    cmd_valid = 1'b0;
    dones = 0;
    k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
      if (done) dones++;
    end
    chk("fill_drained", 32'(busy), 0);
    chk("fill_dones", 32'(dones), 5);
    tick();

    // Abort mid-RUN with two queued
    push(3'b010, 5);
    push(3'b001, 1);
    push(3'b011, 1);
    repeat (5) tick();
    chk("abort_pre_busy", 32'(busy), 1);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = 3'b001;
    cmd_ms    = DUR_W'(2);
    #1;
    chk("abort_ready_low", 32'(cmd_ready), 0);
    tick();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_use", 32'(useServo), 1);
    chk("abort_dir", 32'(direction), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_no_done", 32'(done), 0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy || done || useServo) bad = 1'b1;
    end
    chk("abort_quiet", 32'(bad), 0);

    // Illegal direction {111,5} plays as stop
    push(3'b111, 5);
    wait_strobe(10, n);
    chk("ill_strobe_lat", 32'(n), 2);
    chk("ill_dir", 32'(direction), 0);
    wait_done(100, n, seen);
    chk("ill_run_len", 32'(n), 50);
    tick();
    chk("ill_stop_use", 32'(useServo), 1);
    tick();

    // Zero duration {010,0}
    push(3'b010, 0);
    wait_done(20, n, seen);
    chk("zero_done_lat", 32'(n), 2);
    chk("zero_no_strobe", 32'(seen), 0);
    chk("zero_dir", 32'(direction), 0);
    tick();
    chk("zero_stop_use", 32'(useServo), 1);
    chk("zero_stop_dir", 32'(direction), 0);
    tick();

    // Reset mid-RUN
    push(3'b100, 3);
    wait_strobe(10, n);
    chk("rr_dir", 32'(direction), 4);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("rr_dir_clr", 32'(direction), 0);
    chk("rr_busy_clr", 32'(busy), 0);
    chk("rr_use_clr", 32'(useServo), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rr_init_use", 32'(useServo), 1);
    chk("rr_init_dir", 32'(direction), 0);
    tick();
    chk("rr_idle_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
